// File: rtl/float_sp_pkg.sv
// Single-precision float constants and pipeline types shared by the
// float/fixed converters.
package float_sp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_SIG_W = FP_MAN_W + 1;
  localparam int FP_BIAS  = 127;
  localparam int FIXED_W  = 32;

  localparam logic [FP_EXP_W-1:0] FP_EXP_SPECIAL = '1;
  localparam logic [FIXED_W-1:0]  FIXED_POS_SAT  = 32'h7FFF_FFFF;
  localparam logic [FIXED_W-1:0]  FIXED_NEG_SAT  = 32'h8000_0000;

  // Decoded operand held between the classify and shift stages
  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] expo;
    logic [FP_SIG_W-1:0] sig;
    logic                is_zero;
    logic                is_special;
    logic                is_nan;
  } s1_t;

  // Unsigned magnitude plus status, before the sign is applied
  typedef struct packed {
    logic               sign;
    logic               is_nan;
    logic               invalid;
    logic               inexact;
    logic [FIXED_W-1:0] mag;
  } s2_t;

  // NaN always clamps positive; otherwise clamp toward the operand's sign
  function automatic logic [FIXED_W-1:0] sat_value(input logic sign, input logic is_nan);
    return (sign && !is_nan) ? FIXED_NEG_SAT : FIXED_POS_SAT;
  endfunction

endpackage

// File: rtl/sll.sv
// Logarithmic logical left barrel shifter.
module sll #(
  parameter int p_DATA_WIDTH = 32
) (
  input  logic [p_DATA_WIDTH-1:0]         i_INPUT,
  input  logic [$clog2(p_DATA_WIDTH)-1:0] i_SHIFT_AMOUNT,
  output logic [p_DATA_WIDTH-1:0]         o_RESULT
);

  localparam int lp_LEVELS = $clog2(p_DATA_WIDTH);

  logic [p_DATA_WIDTH-1:0] level_w [lp_LEVELS+1];

  assign level_w[0] = i_INPUT;

  for (genvar gi = 0; gi < lp_LEVELS; gi++) begin : g_level
    assign level_w[gi+1] = i_SHIFT_AMOUNT[gi] ? (level_w[gi] << (1 << gi)) : level_w[gi];
  end

  assign o_RESULT = level_w[lp_LEVELS];

endmodule

// File: rtl/srl.sv
// Logarithmic logical right barrel shifter.
module srl #(
  parameter int p_DATA_WIDTH = 32
) (
  input  logic [p_DATA_WIDTH-1:0]         i_INPUT,
  input  logic [$clog2(p_DATA_WIDTH)-1:0] i_SHIFT_AMOUNT,
  output logic [p_DATA_WIDTH-1:0]         o_RESULT
);

  localparam int lp_LEVELS = $clog2(p_DATA_WIDTH);

  logic [p_DATA_WIDTH-1:0] level_w [lp_LEVELS+1];

  assign level_w[0] = i_INPUT;

  for (genvar gi = 0; gi < lp_LEVELS; gi++) begin : g_level
    assign level_w[gi+1] = i_SHIFT_AMOUNT[gi] ? (level_w[gi] >> (1 << gi)) : level_w[gi];
  end

  assign o_RESULT = level_w[lp_LEVELS];

endmodule

// File: rtl/float_to_fixed_sp.sv
// Pipelined IEEE-754 single-precision to 32-bit signed integer converter,
// truncating toward zero, with optional saturation of invalid results.
module float_to_fixed_sp
  import float_sp_pkg::*;
#(
  parameter int p_SATURATE = 1
) (
  input  logic               i_CLK,
  input  logic               i_RST,
  input  logic               i_VALID,
  input  logic [31:0]        i_FLOAT_WORD,
  output logic               o_VALID,
  output logic signed [31:0] o_FIXED_WORD,
  output logic               o_INVALID,
  output logic               o_INEXACT
);

  localparam int lp_SH_W = $clog2(FIXED_W);

  logic [2:0]               valid_reg;
  logic [31:0]              in_word_reg;
  s1_t                      s1_reg, s1_next;
  s2_t                      s2_reg, s2_next;
  logic signed [FP_EXP_W:0] e_val;
  logic [lp_SH_W-1:0]       srl_amt, sll_amt;
  logic [FIXED_W-1:0]       sig_ext, srl_out, sll_out, drop_mask;
  logic [FIXED_W-1:0]       fixed_next;
  logic                     invalid_next, inexact_next;

  // Valid shift chain: capture, classify, shift; the output register is the last tap
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= {valid_reg[1:0], i_VALID};
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      in_word_reg <= '0;
    end else if (i_VALID) begin
      in_word_reg <= i_FLOAT_WORD;
    end
  end

  always_comb begin
    s1_next            = '0;
    s1_next.sign       = in_word_reg[FIXED_W-1];
    s1_next.expo       = in_word_reg[FP_MAN_W +: FP_EXP_W];
    s1_next.sig        = {1'b1, in_word_reg[FP_MAN_W-1:0]};
    s1_next.is_zero    = (s1_next.expo == '0);
    s1_next.is_special = (s1_next.expo == FP_EXP_SPECIAL);
    s1_next.is_nan     = s1_next.is_special && (in_word_reg[FP_MAN_W-1:0] != '0);
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      s1_reg <= '0;
    end else if (valid_reg[0]) begin
      s1_reg <= s1_next;
    end
  end

  assign e_val     = $signed({1'b0, s1_reg.expo}) - $signed((FP_EXP_W+1)'(FP_BIAS));
  assign sig_ext   = {{(FIXED_W-FP_SIG_W){1'b0}}, s1_reg.sig};
  assign srl_amt   = lp_SH_W'(FP_MAN_W) - e_val[lp_SH_W-1:0];
  assign sll_amt   = e_val[lp_SH_W-1:0] - lp_SH_W'(FP_MAN_W);
  assign drop_mask = ~({FIXED_W{1'b1}} << srl_amt);

  srl #(.p_DATA_WIDTH(FIXED_W)) u_srl (
    .i_INPUT        (sig_ext),
    .i_SHIFT_AMOUNT (srl_amt),
    .o_RESULT       (srl_out)
  );

  sll #(.p_DATA_WIDTH(FIXED_W)) u_sll (
    .i_INPUT        (sig_ext),
    .i_SHIFT_AMOUNT (sll_amt),
    .o_RESULT       (sll_out)
  );

  always_comb begin
    s2_next        = '0;
    s2_next.sign   = s1_reg.sign;
    s2_next.is_nan = s1_reg.is_nan;
    if (s1_reg.is_zero) begin
      s2_next.inexact = (s1_reg.sig[FP_MAN_W-1:0] != '0);
    end else if (s1_reg.is_special) begin
      s2_next.invalid = 1'b1;
    end else if (e_val[FP_EXP_W]) begin
      // Whole significand lies below the binary point; its hidden 1 is lost
      s2_next.inexact = 1'b1;
    end else if (e_val <= 9'sd23) begin
      s2_next.mag     = srl_out;
      s2_next.inexact = |(sig_ext & drop_mask);
    end else if (e_val <= 9'sd30) begin
      s2_next.mag = sll_out;
    end else if (e_val == 9'sd31 && s1_reg.sign && s1_reg.sig[FP_MAN_W-1:0] == '0) begin
      // -2^31 is the one magnitude of 2^31 that fits
      s2_next.mag = FIXED_NEG_SAT;
    end else begin
      s2_next.invalid = 1'b1;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      s2_reg <= '0;
    end else if (valid_reg[1]) begin
      s2_reg <= s2_next;
    end
  end

  always_comb begin
    fixed_next   = '0;
    invalid_next = s2_reg.invalid;
    inexact_next = 1'b0;
    if (s2_reg.invalid) begin
      if (p_SATURATE != 0) begin
        fixed_next = sat_value(s2_reg.sign, s2_reg.is_nan);
      end
    end else begin
      fixed_next   = s2_reg.sign ? (~s2_reg.mag + 1'b1) : s2_reg.mag;
      inexact_next = s2_reg.inexact;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      o_VALID      <= 1'b0;
      o_FIXED_WORD <= '0;
      o_INVALID    <= 1'b0;
      o_INEXACT    <= 1'b0;
    end else begin
      o_VALID <= valid_reg[2];
      if (valid_reg[2]) begin
        o_FIXED_WORD <= fixed_next;
        o_INVALID    <= invalid_next;
        o_INEXACT    <= inexact_next;
      end
    end
  end

endmodule

// File: tb/tb_float_to_fixed_sp.sv
// Bench for float_to_fixed_sp: directed corner cases, randomized traffic against
// a real-arithmetic reference, and mid-stream reset behaviour.
module tb_float_to_fixed_sp;

  logic        i_CLK = 1'b0;
  logic        i_RST = 1'b1;
  logic        i_VALID = 1'b0;
  logic [31:0] i_FLOAT_WORD = '0;

  logic               v_s, v_z, inv_s, inv_z, inx_s, inx_z;
  logic signed [31:0] fx_s, fx_z;

  int n_vec = 0;
  int n_err = 0;
  int edge_cnt = 0;

  localparam int LOG_N = 4096;
  logic        lv_s [LOG_N];
  logic        lv_z [LOG_N];
  logic [31:0] lf_s [LOG_N];
  logic [31:0] lf_z [LOG_N];
  logic        li_s [LOG_N];
  logic        lx_s [LOG_N];
  bit          drv_v [LOG_N];
  logic [31:0] drv_w [LOG_N];

  float_to_fixed_sp #(.p_SATURATE(1)) dut_sat (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_VALID(i_VALID), .i_FLOAT_WORD(i_FLOAT_WORD),
    .o_VALID(v_s), .o_FIXED_WORD(fx_s), .o_INVALID(inv_s), .o_INEXACT(inx_s)
  );

  float_to_fixed_sp #(.p_SATURATE(0)) dut_zero (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_VALID(i_VALID), .i_FLOAT_WORD(i_FLOAT_WORD),
    .o_VALID(v_z), .o_FIXED_WORD(fx_z), .o_INVALID(inv_z), .o_INEXACT(inx_z)
  );

  always #5 i_CLK = ~i_CLK;

  // Output log indexed by rising-edge number
  always @(posedge i_CLK) begin
    #1;
    edge_cnt = edge_cnt + 1;
    if (edge_cnt < LOG_N) begin
      lv_s[edge_cnt] = v_s;
      lv_z[edge_cnt] = v_z;
      lf_s[edge_cnt] = fx_s;
      lf_z[edge_cnt] = fx_z;
      li_s[edge_cnt] = inv_s;
      lx_s[edge_cnt] = inx_s;
    end
  end

  // Reference: value of the float as a real, truncated toward zero
  function automatic void model(input logic [31:0] w, input bit sat,
                                output logic [31:0] fx, output bit inv, output bit inx);
    int  ex;
    int  t;
    real r;
    ex  = int'(w[30:23]);
    fx  = 32'h0;
    inv = 1'b0;
    inx = 1'b0;
    if (ex == 255) begin
      inv = 1'b1;
      if (sat) fx = (w[31] && w[22:0] == 23'h0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return;
    end
    if (ex == 0) r = real'(w[22:0]) * (2.0 ** (-149.0));
    else         r = (8388608.0 + real'(w[22:0])) * (2.0 ** (real'(ex) - 150.0));
    if (w[31]) r = -r;
    if (r >= 2147483648.0 || r < -2147483648.0) begin
      inv = 1'b1;
      if (sat) fx = w[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return;
    end
    t   = $rtoi(r);
    fx  = t;
    inx = (real'(t) != r);
  endfunction

  task automatic drive(input bit v, input logic [31:0] w, input bit rst, output int k);
    @(negedge i_CLK);
    i_VALID      = v;
    i_FLOAT_WORD = w;
    i_RST        = rst;
    k            = edge_cnt + 1;
    if (k < LOG_N) begin
      drv_v[k] = v;
      drv_w[k] = w;
    end
  endtask

  task automatic idle(input int n);
    int k;
    repeat (n) drive(1'b0, $urandom, 1'b0, k);
  endtask

  function automatic logic [31:0] rand_float();
    logic [31:0] w;
    logic [7:0]  ex;
    w  = $urandom;
    ex = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(110, 165));
    w[30:23] = ex;
    if ($urandom_range(0, 7) == 0) w[22:0] = 23'h0;
    return w;
  endfunction

  task automatic test_reset();
    int k0, k1;
    drive(1'b1, 32'h3F80_0000, 1'b1, k0);
    drive(1'b0, 32'h0, 1'b1, k1);
    idle(4);
    for (int e = k0; e <= k0 + 4; e++) begin
      n_vec++;
      if (lv_s[e] !== 1'b0 || lv_z[e] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_valid edge=%0d got=%b/%b want=0", e, lv_s[e], lv_z[e]);
      end
      n_vec++;
      if (lf_s[e] !== 32'h0 || li_s[e] !== 1'b0 || lx_s[e] !== 1'b0 || lf_z[e] !== 32'h0) begin
        n_err++;
        $display("FAIL reset_outputs edge=%0d got=%h/%b/%b want=00000000/0/0", e, lf_s[e], li_s[e], lx_s[e]);
      end
    end
    $display("reset: outputs checked over edges %0d..%0d", k0, k0 + 4);
  endtask

  task automatic test_directed();
    logic [31:0] tw [16] = '{32'h3F80_0000, 32'h4EFF_FFFF, 32'hC049_0FDB, 32'h3F00_0000,
                             32'h4F00_0000, 32'hCF00_0000, 32'h7FC0_0000, 32'hFF80_0000,
                             32'h0000_0001, 32'h8000_0000, 32'h7F80_0000, 32'hCF00_0001,
                             32'h4B00_0001, 32'h4B80_0001, 32'hFFC0_0000, 32'hBF7F_FFFF};
    logic [31:0] tf [16] = '{32'h0000_0001, 32'h7FFF_FF80, 32'hFFFF_FFFD, 32'h0000_0000,
                             32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000,
                             32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000,
                             32'h0080_0001, 32'h0100_0002, 32'h7FFF_FFFF, 32'h0000_0000};
    bit ti [16] = '{0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 0};
    bit tx [16] = '{0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    int kk [16];
    logic [31:0] zf;
    for (int i = 0; i < 16; i++) drive(1'b1, tw[i], 1'b0, kk[i]);
    idle(5);
    for (int i = 0; i < 16; i++) begin
      int e;
      e  = kk[i] + 3;
      zf = ti[i] ? 32'h0 : tf[i];
      n_vec++;
      if (lv_s[e] !== 1'b1 || lv_z[e] !== 1'b1) begin
        n_err++;
        $display("FAIL directed_valid in=%h got=%b/%b want=1", tw[i], lv_s[e], lv_z[e]);
      end
      n_vec++;
      if (lf_s[e] !== tf[i] || li_s[e] !== ti[i] || lx_s[e] !== tx[i]) begin
        n_err++;
        $display("FAIL directed_sat in=%h got=%h inv=%b inx=%b want=%h inv=%b inx=%b",
                 tw[i], lf_s[e], li_s[e], lx_s[e], tf[i], ti[i], tx[i]);
      end
      n_vec++;
      if (lf_z[e] !== zf) begin
        n_err++;
        $display("FAIL directed_nosat in=%h got=%h want=%h", tw[i], lf_z[e], zf);
      end
      $display("directed: in=%h out=%h inv=%b inx=%b nosat=%h", tw[i], lf_s[e], li_s[e], lx_s[e], lf_z[e]);
    end
  endtask

  task automatic test_random();
    int k, k0, kl;
    bit v;
    logic [31:0] hf, zf;
    bit hi, hx, zi, zx;
    bit seen;
    k0 = 0;
    kl = 0;
    for (int i = 0; i < 300; i++) begin
      v = (i == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      drive(v, rand_float(), 1'b0, k);
      if (i == 0) k0 = k;
      kl = k;
    end
    idle(5);
    seen = 1'b0;
    hf = '0; zf = '0; hi = 1'b0; hx = 1'b0;
    for (int e = k0 + 3; e <= kl + 3; e++) begin
      n_vec++;
      if (lv_s[e] !== drv_v[e-3] || lv_z[e] !== drv_v[e-3]) begin
        n_err++;
        $display("FAIL random_valid edge=%0d got=%b/%b want=%b", e, lv_s[e], lv_z[e], drv_v[e-3]);
      end
      if (drv_v[e-3]) begin
        model(drv_w[e-3], 1'b1, hf, hi, hx);
        model(drv_w[e-3], 1'b0, zf, zi, zx);
        seen = 1'b1;
      end
      if (seen) begin
        n_vec++;
        if (lf_s[e] !== hf || li_s[e] !== hi || lx_s[e] !== hx || lf_z[e] !== zf) begin
          n_err++;
          $display("FAIL random_data edge=%0d in=%h got=%h inv=%b inx=%b nosat=%h want=%h inv=%b inx=%b nosat=%h",
                   e, drv_w[e-3], lf_s[e], li_s[e], lx_s[e], lf_z[e], hf, hi, hx, zf);
        end
      end
      if (drv_v[e-3])
        $display("random: in=%h out=%h inv=%b inx=%b", drv_w[e-3], lf_s[e], li_s[e], lx_s[e]);
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] pw [5] = '{32'h4120_0000, 32'hC2C8_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    bit pv [5] = '{1, 1, 0, 1, 1};
    int kk [5];
    int kr, kn;
    logic [31:0] ef;
    bit ei, ex;
    for (int i = 0; i < 5; i++) drive(pv[i], pw[i], 1'b0, kk[i]);
    drive(1'b1, 32'h4480_0000, 1'b1, kr);
    drive(1'b1, 32'hC1A0_0000, 1'b0, kn);
    idle(6);
    for (int i = 0; i < 2; i++) begin
      model(pw[i], 1'b1, ef, ei, ex);
      n_vec++;
      if (lv_s[kk[i]+3] !== 1'b1 || lf_s[kk[i]+3] !== ef) begin
        n_err++;
        $display("FAIL midrst_pre edge=%0d got v=%b %h want v=1 %h", kk[i] + 3, lv_s[kk[i]+3], lf_s[kk[i]+3], ef);
      end
    end
    for (int e = kk[2] + 3; e < kn + 3; e++) begin
      bit want_quiet;
      want_quiet = (e >= kr);
      n_vec++;
      if (lv_s[e] !== 1'b0 || lv_z[e] !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_valid edge=%0d got=%b/%b want=0", e, lv_s[e], lv_z[e]);
      end
      if (want_quiet) begin
        n_vec++;
        if (lf_s[e] !== 32'h0 || li_s[e] !== 1'b0 || lx_s[e] !== 1'b0) begin
          n_err++;
          $display("FAIL midrst_outputs edge=%0d got=%h/%b/%b want=00000000/0/0", e, lf_s[e], li_s[e], lx_s[e]);
        end
      end
    end
    model(32'hC1A0_0000, 1'b1, ef, ei, ex);
    n_vec++;
    if (lv_s[kn+3] !== 1'b1 || lf_s[kn+3] !== ef || li_s[kn+3] !== ei || lx_s[kn+3] !== ex) begin
      n_err++;
      $display("FAIL midrst_post edge=%0d got v=%b %h want v=1 %h", kn + 3, lv_s[kn+3], lf_s[kn+3], ef);
    end
    n_vec++;
    if (lv_s[kn+4] !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_tail edge=%0d got=%b want=0", kn + 4, lv_s[kn+4]);
    end
    $display("reset_midstream: post-reset operand C1A00000 out=%h valid=%b", lf_s[kn+3], lv_s[kn+3]);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
